vme_slave_ctrl: RTL and testbench
=================================

Name: vme_slave_ctrl

Overview:
- VME A16/D16 slave cycle controller for the register page 0x7C80–0x7CBF.
- Synchronises the asynchronous VME strobes and latches address, AM and data.
- Decodes the address to a register index, issues single-cycle read/write strobes to the register bank, and drives DTACK*/BERR* and the data-bus output enable.
- Sits between the VME transceivers and the board register file.

Parameters:
- BASE_HI, 8'h7C, required value of ADDR[15:8].
- WAIT_CYC, 2, CLK cycles from the strobe to DTACK assertion (range 1–15). The read data-capture point is also set by this value.
- TIMEOUT, 255, CLK cycles allowed in ACK/ERR before a forced release (range 1–255).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- AS_N  in  1  VME address strobe, asynchronous
- DS0_N  in  1  VME data strobe 0, asynchronous
- DS1_N  in  1  VME data strobe 1, asynchronous
- WRITE_N  in  1  VME write (0 = write)
- AM  in  6  address modifier
- ADDR  in  16  VME address
- DATA_IN  in  16  VME data, write direction
- DATA_OUT  out  16  VME data, read direction
- DATA_OE  out  1  enable for the read-direction data transceiver
- DTACK_N  out  1  data acknowledge, active low
- BERR_N  out  1  bus error, active low
- REG_IDX  out  4  register index, 0–12
- REG_WR  out  1  one-cycle write strobe
- REG_RD  out  1  one-cycle read strobe
- REG_WDATA  out  16  latched write data
- REG_RDATA  in  16  register bank read data, valid WAIT_CYC-1 cycles after REG_RD
- TIMEOUT_ERR  out  1  one-cycle pulse on a forced release

Behaviour:
- **Synchronisation:** AS_N, DS0_N and DS1_N each pass through 2-flop synchronisers. as_s/ds_any_s/ds_both_s are the active-high synced versions. ADDR, AM, WRITE_N and DATA_IN are sampled only in IDLE→DECODE.
- **Reset:** on the next CLK edge with RST=1, the FSM goes to IDLE and all outputs take these values:
  - DTACK_N=1, BERR_N=1, DATA_OE=0, DATA_OUT=0
  - REG_WR=0, REG_RD=0, REG_IDX=0, REG_WDATA=0, TIMEOUT_ERR=0
  - counters=0, synchronisers=1 (inactive).
  - A reset mid-cycle releases the bus immediately.
- **Map:** index is assigned as follows; any other offset in the page is unmapped.
  - 0x7C80 + 2k → index k, for k = 0–8
  - 0x7C96 → 9
  - 0x7CA0 → 10
  - 0x7CA2 → 11
  - 0x7CA4 → 12
- **Selected:** ADDR[15:8]==BASE_HI, ADDR[7:6]==2'b10, and AM ∈ {0x29, 0x2D}.

FSM states: IDLE, DECODE, WAIT, ACK, ERR, IGNORE, RELEASE.
- **IDLE:** when as_s & ds_any_s, latch the inputs → DECODE.
- **DECODE (1 cycle):**
  - Not selected → IGNORE.
  - Selected and (unmapped, or ds_both_s==0, i.e. byte access) → ERR.
  - Otherwise:
    - Set REG_IDX.
    - Write: REG_WR=1 for this cycle only, with REG_WDATA = latched data.
    - Read: REG_RD=1 for this cycle only.
    - → WAIT, counter=1.
- **WAIT:**
  - Counter increments each cycle. Reaching WAIT_CYC → ACK.
  - On a read, DATA_OUT<=REG_RDATA on the transition cycle.
  - If as_s drops in WAIT: abort → IDLE with no DTACK. An already-issued REG_WR is not undone.
- **ACK:**
  - DTACK_N=0; DATA_OE = read.
  - When ds_any_s==0 → RELEASE.
- **ERR:** BERR_N=0 until ds_any_s==0 → RELEASE.
- **IGNORE:** no outputs driven; when as_s==0 → IDLE.
- **RELEASE:**
  - DTACK_N=1, BERR_N=1, DATA_OE=0 in the same cycle.
  - Wait for as_s==0 → IDLE. This also covers address-pipelined masters that keep AS low.
- **Timeout:**
  - A counter runs in ACK/ERR. At TIMEOUT: pulse TIMEOUT_ERR, deassert everything, → IGNORE.
- **Strobe rules:**
  - REG_WR and REG_RD are never both high.
  - At most one strobe per VME cycle.
  - A new cycle is never started without first seeing as_s==0.
- **Latency:** DTACK falls 2 (sync) + 1 (DECODE) + WAIT_CYC cycles after DS falls.

Decomposition:
- **Package vme_pkg:**
  - BASE_HI default, AM_A16_USER=6'h29, AM_A16_SUP=6'h2D
  - index constants REG_7C80..REG_7CA4 (0–12)
  - FSM state enum.
- **Sub-module vme_reg_map:** combinational ADDR[7:0] → {mapped, idx[3:0]}. The FSM lives in vme_slave_ctrl.

Test Plan:
- **Write:** AM=0x29, ADDR=0x7C84, DATA_IN=0xA5A5, write, both DS → REG_WR single pulse with REG_IDX=2, REG_WDATA=0xA5A5; DTACK_N low 5 cycles after DS (WAIT_CYC=2); releases 1 cycle after synced DS rises.
- **Read:** ADDR=0x7CA4, REG_RDATA=0x1234 → REG_RD pulse with IDX=12; DATA_OUT=0x1234 and DATA_OE=1 while DTACK_N=0; DATA_OE=0 in the RELEASE cycle.
- **Unmapped:** ADDR=0x7C92 read → BERR_N=0, no REG_RD/REG_WR, DTACK_N stays 1. Byte access (DS1_N only) to 0x7C80 → BERR_N=0.
- **Not selected:** ADDR=0x7D80, or AM=0x3D → no strobes, DTACK_N/BERR_N stay 1; next valid cycle to 0x7C96 gives IDX=9.
- **Timeout:** TIMEOUT=8, DS held low after DTACK → TIMEOUT_ERR pulse 8 cycles after ACK entry, DTACK_N=1; no new cycle until AS_N goes high.
- **Reset/abort:**
  - RST=1 during ACK → next edge DTACK_N=1, DATA_OE=0, FSM in IDLE.
  - AS_N high during WAIT → no DTACK, FSM in IDLE.

Source files
------------

// File: rtl/vme_pkg.sv
// Shared constants, register index map and FSM state type for the VME A16/D16 slave.
package vme_pkg;

    localparam logic [7:0] BASE_HI_DEF = 8'h7C;
    localparam logic [5:0] AM_A16_USER = 6'h29;
    localparam logic [5:0] AM_A16_SUP  = 6'h2D;

    localparam logic [3:0] REG_7C80 = 4'd0;
    localparam logic [3:0] REG_7C82 = 4'd1;
    localparam logic [3:0] REG_7C84 = 4'd2;
    localparam logic [3:0] REG_7C86 = 4'd3;
    localparam logic [3:0] REG_7C88 = 4'd4;
    localparam logic [3:0] REG_7C8A = 4'd5;
    localparam logic [3:0] REG_7C8C = 4'd6;
    localparam logic [3:0] REG_7C8E = 4'd7;
    localparam logic [3:0] REG_7C90 = 4'd8;
    localparam logic [3:0] REG_7C96 = 4'd9;
    localparam logic [3:0] REG_7CA0 = 4'd10;
    localparam logic [3:0] REG_7CA2 = 4'd11;
    localparam logic [3:0] REG_7CA4 = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_ACK,
        ST_ERR,
        ST_IGNORE,
        ST_RELEASE
    } vme_state_e;

    function automatic logic am_is_a16(input logic [5:0] am);
        return (am == AM_A16_USER) || (am == AM_A16_SUP);
    endfunction

endpackage

// File: rtl/vme_reg_map.sv
// Register page decode: low address byte to register index, with a mapped flag.
module vme_reg_map
    import vme_pkg::*;
(
    input  logic [7:0] off_i,
    output logic       mapped_o,
    output logic [3:0] idx_o
);

    always_comb begin
        mapped_o = 1'b1;
        idx_o    = REG_7C80;
        case (off_i)
            8'h80: idx_o = REG_7C80;
            8'h82: idx_o = REG_7C82;
            8'h84: idx_o = REG_7C84;
            8'h86: idx_o = REG_7C86;
            8'h88: idx_o = REG_7C88;
            8'h8A: idx_o = REG_7C8A;
            8'h8C: idx_o = REG_7C8C;
            8'h8E: idx_o = REG_7C8E;
            8'h90: idx_o = REG_7C90;
            8'h96: idx_o = REG_7C96;
            8'hA0: idx_o = REG_7CA0;
            8'hA2: idx_o = REG_7CA2;
            8'hA4: idx_o = REG_7CA4;
            default: mapped_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/vme_slave_ctrl.sv
// VME A16/D16 slave cycle controller: strobe sync, decode, register strobes, DTACK*/BERR*.
//   state   | meaning
//   IDLE    | waiting for synced AS and any DS
//   DECODE  | one cycle: select/map check, issue REG_WR or REG_RD
//   WAIT    | access delay before DTACK, read data captured on exit
//   ACK     | DTACK* driven until DS released (or timeout)
//   ERR     | BERR* driven until DS released (or timeout)
//   IGNORE  | not ours or timed out; wait for AS release
//   RELEASE | bus released; wait for AS release before next cycle
module vme_slave_ctrl
    import vme_pkg::*;
#(
    parameter logic [7:0]  BASE_HI  = BASE_HI_DEF,
    parameter int unsigned WAIT_CYC = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        AS_N,
    input  logic        DS0_N,
    input  logic        DS1_N,
    input  logic        WRITE_N,
    input  logic [5:0]  AM,
    input  logic [15:0] ADDR,
    input  logic [15:0] DATA_IN,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    output logic        DTACK_N,
    output logic        BERR_N,
    output logic [3:0]  REG_IDX,
    output logic        REG_WR,
    output logic        REG_RD,
    output logic [15:0] REG_WDATA,
    input  logic [15:0] REG_RDATA,
    output logic        TIMEOUT_ERR
);

    vme_state_e  state_q, state_d;

    logic [1:0]  as_sync_q, ds0_sync_q, ds1_sync_q;
    logic        as_s, ds_any_s, ds_both_s;

    logic        write_n_q, sel_q, mapped_q;
    logic [3:0]  idx_q;
    logic [15:0] wdata_q, data_out_q;
    logic [7:0]  cnt_q;
    logic        to_err_q;

    logic        map_mapped;
    logic [3:0]  map_idx;
    logic        sel_live, go, wait_done, to_done;

    vme_reg_map u_map (
        .off_i    (ADDR[7:0]),
        .mapped_o (map_mapped),
        .idx_o    (map_idx)
    );

    assign as_s      = ~as_sync_q[1];
    assign ds_any_s  = ~ds0_sync_q[1] | ~ds1_sync_q[1];
    assign ds_both_s = ~ds0_sync_q[1] & ~ds1_sync_q[1];

    assign sel_live  = (ADDR[15:8] == BASE_HI) && (ADDR[7:6] == 2'b10) && am_is_a16(AM);
    assign go        = (state_q == ST_DECODE) && sel_q && mapped_q && ds_both_s;
    assign wait_done = cnt_q >= 8'(WAIT_CYC - 1);
    assign to_done   = cnt_q == 8'(TIMEOUT - 1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (as_s && ds_any_s) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (!sel_q)                       state_d = ST_IGNORE;
                else if (!mapped_q || !ds_both_s) state_d = ST_ERR;
                else                              state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!as_s)          state_d = ST_IDLE;
                else if (wait_done) state_d = ST_ACK;
            end
            ST_ACK, ST_ERR: begin
                if (to_done)        state_d = ST_IGNORE;
                else if (!ds_any_s) state_d = ST_RELEASE;
            end
            ST_IGNORE, ST_RELEASE: begin
                if (!as_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        DTACK_N = 1'b1;
        BERR_N  = 1'b1;
        DATA_OE = 1'b0;
        REG_WR  = 1'b0;
        REG_RD  = 1'b0;
        if (state_q == ST_ACK) begin
            DTACK_N = 1'b0;
            DATA_OE = write_n_q;
        end
        if (state_q == ST_ERR) BERR_N = 1'b0;
        if (go) begin
            REG_WR = ~write_n_q;
            REG_RD = write_n_q;
        end
    end

    // Single counter: access delay in WAIT, then timeout in ACK/ERR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            as_sync_q  <= 2'b11;
            ds0_sync_q <= 2'b11;
            ds1_sync_q <= 2'b11;
            write_n_q  <= 1'b1;
            sel_q      <= 1'b0;
            mapped_q   <= 1'b0;
            idx_q      <= 4'd0;
            wdata_q    <= 16'd0;
            data_out_q <= 16'd0;
            cnt_q      <= 8'd0;
            to_err_q   <= 1'b0;
        end else begin
            as_sync_q  <= {as_sync_q[0], AS_N};
            ds0_sync_q <= {ds0_sync_q[0], DS0_N};
            ds1_sync_q <= {ds1_sync_q[0], DS1_N};
            to_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= 8'd0;
                    if (state_d == ST_DECODE) begin
                        write_n_q <= WRITE_N;
                        wdata_q   <= DATA_IN;
                        sel_q     <= sel_live;
                        mapped_q  <= map_mapped;
                        if (sel_live && map_mapped) idx_q <= map_idx;
                    end
                end
                ST_DECODE: begin
                    cnt_q <= go ? 8'd1 : 8'd0;
                end
                ST_WAIT: begin
                    if (state_d == ST_ACK) begin
                        cnt_q <= 8'd0;
                        if (write_n_q) data_out_q <= REG_RDATA;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_ACK, ST_ERR: begin
                    if (to_done) begin
                        to_err_q <= 1'b1;
                        cnt_q    <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: cnt_q <= 8'd0;
            endcase
        end
    end

    assign REG_IDX     = idx_q;
    assign REG_WDATA   = wdata_q;
    assign DATA_OUT    = data_out_q;
    assign TIMEOUT_ERR = to_err_q;

endmodule

// File: tb/tb_vme_slave_ctrl.sv
// Directed bench for vme_slave_ctrl (WAIT_CYC=2, TIMEOUT=8); inputs change and outputs are sampled on negedge.
module tb_vme_slave_ctrl;
    import vme_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        AS_N, DS0_N, DS1_N, WRITE_N;
    logic [5:0]  AM;
    logic [15:0] ADDR, DATA_IN, DATA_OUT, REG_WDATA, REG_RDATA;
    logic        DATA_OE, DTACK_N, BERR_N, REG_WR, REG_RD, TIMEOUT_ERR;
    logic [3:0]  REG_IDX;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;

    vme_slave_ctrl #(.BASE_HI(8'h7C), .WAIT_CYC(2), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST), .AS_N(AS_N), .DS0_N(DS0_N), .DS1_N(DS1_N),
        .WRITE_N(WRITE_N), .AM(AM), .ADDR(ADDR), .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DTACK_N(DTACK_N), .BERR_N(BERR_N),
        .REG_IDX(REG_IDX), .REG_WR(REG_WR), .REG_RD(REG_RD), .REG_WDATA(REG_WDATA),
        .REG_RDATA(REG_RDATA), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (REG_WR) wr_cnt++;
        if (REG_RD) rd_cnt++;
        if (REG_WR && REG_RD) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic start_cycle(input logic [5:0] am, input logic [15:0] addr, input logic wn,
                               input logic [15:0] din, input logic ds0n, input logic ds1n);
        AM = am; ADDR = addr; WRITE_N = wn; DATA_IN = din;
        AS_N = 1'b0; DS0_N = ds0n; DS1_N = ds1n;
    endtask

    task automatic end_cycle(input string tag);
        DS0_N = 1'b1; DS1_N = 1'b1; AS_N = 1'b1;
        nclk(4);
        check(tag, 32'(dut.state_q), 32'(ST_IDLE));
    endtask

    initial begin
        RST = 1'b1; AS_N = 1'b1; DS0_N = 1'b1; DS1_N = 1'b1; WRITE_N = 1'b1;
        AM = 6'h00; ADDR = 16'h0000; DATA_IN = 16'h0000; REG_RDATA = 16'h0000;
        nclk(3);
        check("rst_dtack", 32'(DTACK_N), 32'd1);
        check("rst_berr", 32'(BERR_N), 32'd1);
        check("rst_oe", 32'(DATA_OE), 32'd0);
        check("rst_dout", 32'(DATA_OUT), 32'h0);
        check("rst_strobes", 32'({REG_WR, REG_RD, TIMEOUT_ERR}), 32'd0);
        check("rst_idx", 32'(REG_IDX), 32'd0);
        check("rst_wdata", 32'(REG_WDATA), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        RST = 1'b0;
        nclk(2);

        // Write 0x7C84 <- 0xA5A5
        start_cycle(6'h29, 16'h7C84, 1'b0, 16'hA5A5, 1'b0, 1'b0);
        nclk(3);
        check("wr_pulse", 32'({REG_WR, REG_RD}), 32'b10);
        check("wr_idx", 32'(REG_IDX), 32'd2);
        check("wr_wdata", 32'(REG_WDATA), 32'hA5A5);
        nclk(1);
        check("wr_pulse_end", 32'(REG_WR), 32'd0);
        check("wr_dtack_early", 32'(DTACK_N), 32'd1);
        nclk(1);
        check("wr_dtack", 32'(DTACK_N), 32'd0);
        check("wr_oe", 32'(DATA_OE), 32'd0);
        DS0_N = 1'b1; DS1_N = 1'b1;
        nclk(2);
        check("wr_dtack_hold", 32'(DTACK_N), 32'd0);
        nclk(1);
        check("wr_release", 32'(DTACK_N), 32'd1);
        check("wr_rel_state", 32'(dut.state_q), 32'(ST_RELEASE));
        nclk(2);
        check("wr_rel_as_low", 32'(dut.state_q), 32'(ST_RELEASE));
        end_cycle("wr_idle");
        check("wr_count", 32'(wr_cnt), 32'd1);

        // Read 0x7CA4 -> 0x1234
        REG_RDATA = 16'h1234;
        start_cycle(6'h2D, 16'h7CA4, 1'b1, 16'h0000, 1'b0, 1'b0);
        nclk(3);
        check("rd_pulse", 32'({REG_WR, REG_RD}), 32'b01);
        check("rd_idx", 32'(REG_IDX), 32'd12);
        nclk(2);
        check("rd_dtack", 32'(DTACK_N), 32'd0);
        check("rd_oe", 32'(DATA_OE), 32'd1);
        check("rd_dout", 32'(DATA_OUT), 32'h1234);
        DS0_N = 1'b1; DS1_N = 1'b1;
        nclk(2);
        check("rd_oe_hold", 32'(DATA_OE), 32'd1);
        nclk(1);
        check("rd_rel_oe", 32'(DATA_OE), 32'd0);
        check("rd_rel_dtack", 32'(DTACK_N), 32'd1);
        end_cycle("rd_idle");
        check("rd_count", 32'(rd_cnt), 32'd1);

        // Unmapped offset in page
        start_cycle(6'h29, 16'h7C92, 1'b1, 16'h0000, 1'b0, 1'b0);
        nclk(4);
        check("unm_berr", 32'(BERR_N), 32'd0);
        check("unm_dtack", 32'(DTACK_N), 32'd1);
        DS0_N = 1'b1; DS1_N = 1'b1;
        nclk(2);
        check("unm_berr_hold", 32'(BERR_N), 32'd0);
        nclk(1);
        check("unm_berr_rel", 32'(BERR_N), 32'd1);
        end_cycle("unm_idle");
        check("unm_strobes", 32'(wr_cnt + rd_cnt), 32'd2);

        // Byte access (DS1 only)
        start_cycle(6'h29, 16'h7C80, 1'b0, 16'h5555, 1'b1, 1'b0);
        nclk(4);
        check("byte_berr", 32'(BERR_N), 32'd0);
        check("byte_dtack", 32'(DTACK_N), 32'd1);
        end_cycle("byte_idle");
        check("byte_wr", 32'(wr_cnt), 32'd1);

        // Not selected: wrong page, then wrong AM
        start_cycle(6'h29, 16'h7D80, 1'b0, 16'h1111, 1'b0, 1'b0);
        nclk(4);
        check("nsel_state", 32'(dut.state_q), 32'(ST_IGNORE));
        nclk(2);
        check("nsel_bus", 32'({DTACK_N, BERR_N}), 32'b11);
        end_cycle("nsel_idle");
        start_cycle(6'h3D, 16'h7C80, 1'b0, 16'h2222, 1'b0, 1'b0);
        nclk(6);
        check("nam_bus", 32'({DTACK_N, BERR_N}), 32'b11);
        end_cycle("nam_idle");
        check("nsel_strobes", 32'(wr_cnt + rd_cnt), 32'd2);
        start_cycle(6'h29, 16'h7C96, 1'b1, 16'h0000, 1'b0, 1'b0);
        nclk(3);
        check("r96_pulse", 32'(REG_RD), 32'd1);
        check("r96_idx", 32'(REG_IDX), 32'd9);
        nclk(2);
        check("r96_dtack", 32'(DTACK_N), 32'd0);
        end_cycle("r96_idle");

        // Timeout: DS held low after DTACK
        start_cycle(6'h29, 16'h7C90, 1'b0, 16'h0F0F, 1'b0, 1'b0);
        nclk(5);
        check("to_dtack", 32'(DTACK_N), 32'd0);
        nclk(7);
        check("to_pre", 32'({DTACK_N, TIMEOUT_ERR}), 32'b00);
        nclk(1);
        check("to_pulse", 32'(TIMEOUT_ERR), 32'd1);
        check("to_dtack_rel", 32'(DTACK_N), 32'd1);
        check("to_state", 32'(dut.state_q), 32'(ST_IGNORE));
        nclk(1);
        check("to_pulse_end", 32'(TIMEOUT_ERR), 32'd0);
        nclk(5);
        check("to_hold", 32'(dut.state_q), 32'(ST_IGNORE));
        check("to_no_new", 32'(wr_cnt + rd_cnt), 32'd4);
        end_cycle("to_idle");

        // Reset during ACK of a read
        REG_RDATA = 16'hBEEF;
        start_cycle(6'h29, 16'h7C80, 1'b1, 16'h0000, 1'b0, 1'b0);
        nclk(5);
        check("rack_oe", 32'(DATA_OE), 32'd1);
        check("rack_dout", 32'(DATA_OUT), 32'hBEEF);
        RST = 1'b1;
        nclk(1);
        check("rack_dtack", 32'(DTACK_N), 32'd1);
        check("rack_oe_rst", 32'(DATA_OE), 32'd0);
        check("rack_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("rack_dout_rst", 32'(DATA_OUT), 32'h0);
        RST = 1'b0;
        end_cycle("rack_idle");

        // Abort: AS released during WAIT
        start_cycle(6'h29, 16'h7C82, 1'b1, 16'h0000, 1'b0, 1'b0);
        nclk(2);
        AS_N = 1'b1;
        nclk(1);
        check("abt_idx", 32'(REG_IDX), 32'd1);
        nclk(1);
        check("abt_wait", 32'(dut.state_q), 32'(ST_WAIT));
        nclk(1);
        check("abt_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("abt_dtack", 32'(DTACK_N), 32'd1);
        nclk(2);
        check("abt_dtack_late", 32'(DTACK_N), 32'd1);
        end_cycle("abt_end");

        check("tot_wr", 32'(wr_cnt), 32'd2);
        check("tot_rd", 32'(rd_cnt), 32'd4);
        check("never_both", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
